// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the register-file access path.
package reg_file_pkg;

  localparam int unsigned RF_WORD_W = 32;
  localparam int unsigned RF_BE_W   = 4;

  typedef logic [RF_WORD_W-1:0] rf_word_t;
  typedef logic [RF_BE_W-1:0]   rf_be_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } rf_op_e;

  function automatic int unsigned word_addr_width(input int unsigned byte_aw);
    return byte_aw - 2;
  endfunction

endpackage

// File: rtl/reg_file_access_ctrl_rr_arbiter.sv
// Round-robin arbiter with a combinational grant; RF_CTRL_FIXED_PRIO_EN
// swaps it for fixed lowest-index-wins priority with no pointer state.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     grant_idx_o
);

`ifdef RF_CTRL_FIXED_PRIO_EN

  logic unused_sigs;
  assign unused_sigs = ^{clk, rst_n, advance_i};

  always_comb begin
    logic found;
    found       = 1'b0;
    grant_o     = '0;
    grant_idx_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i]) begin
        found       = 1'b1;
        grant_o[i]  = 1'b1;
        grant_idx_o = IDW'(i);
      end
    end
  end

`else

  logic [IDW-1:0] ptr_q, ptr_d;

  // Scan starts at the pointer and wraps, so the most recent winner ends up last.
  always_comb begin
    logic        found;
    int unsigned idx;
    found       = 1'b0;
    idx         = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      if (grant_idx_o == IDW'(NUM_REQ - 1)) ptr_d = '0;
      else                                  ptr_d = grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

`endif

endmodule

// File: rtl/reg_file_access_ctrl.sv
// Shares register-file read port 0 and the write port among NUM_REQ requesters.
// Optional macro RF_CTRL_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module reg_file_access_ctrl
  import reg_file_pkg::*;
#(
  parameter int unsigned BYTE_ADDR_WIDTH = 6,
  parameter int unsigned NUM_REQ         = 2,
  localparam int unsigned WA             = word_addr_width(BYTE_ADDR_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*WA-1:0]        req_addr,
  input  logic [NUM_REQ*RF_BE_W-1:0]   req_byte_en,
  input  logic [NUM_REQ*RF_WORD_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output rf_word_t                     rsp_rdata,
  output logic                         rf_rd_en,
  output logic [WA-1:0]                rf_rd_addr,
  input  rf_word_t                     rf_rd_data,
  output logic                         rf_wr_en,
  output logic [WA-1:0]                rf_wr_addr,
  output rf_be_t                       rf_byte_en,
  output rf_word_t                     rf_wr_data
);

  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     gidx;
  logic               gnt_any;
  rf_op_e             gnt_op;
  logic [WA-1:0]      gnt_addr;
  rf_be_t             gnt_be;
  rf_word_t           gnt_wdata;

  logic           rsp_pending_q, rsp_pending_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_is_read_q, rsp_is_read_d;

  assign gnt_any   = |grant;
  assign req_ready = grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_valid),
    .advance_i   (gnt_any),
    .grant_o     (grant),
    .grant_idx_o (gidx)
  );

  // Each register-file field is driven only for its own operation, else held at 0.
  always_comb begin
    gnt_op     = rf_op_e'(req_we[gidx]);
    gnt_addr   = req_addr[gidx*WA +: WA];
    gnt_be     = req_byte_en[gidx*RF_BE_W +: RF_BE_W];
    gnt_wdata  = req_wdata[gidx*RF_WORD_W +: RF_WORD_W];
    rf_rd_en   = gnt_any && (gnt_op == OP_READ);
    rf_wr_en   = gnt_any && (gnt_op == OP_WRITE);
    rf_rd_addr = rf_rd_en ? gnt_addr : '0;
    rf_wr_addr = rf_wr_en ? gnt_addr : '0;
    rf_byte_en = rf_wr_en ? gnt_be : '0;
    rf_wr_data = rf_wr_en ? gnt_wdata : '0;
  end

  always_comb begin
    rsp_pending_d = gnt_any;
    rsp_id_d      = gidx;
    rsp_is_read_d = rf_rd_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pending_q <= 1'b0;
      rsp_id_q      <= '0;
      rsp_is_read_q <= 1'b0;
    end else begin
      rsp_pending_q <= rsp_pending_d;
      rsp_id_q      <= rsp_id_d;
      rsp_is_read_q <= rsp_is_read_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (rsp_pending_q) rsp_valid[rsp_id_q] = 1'b1;
  end

  assign rsp_rdata = (rsp_pending_q && rsp_is_read_q) ? rf_rd_data : '0;

endmodule
